// File: rtl/id_ex_stage_if.sv
// ID -> EX handshake and bundle for the ID/EX pipeline register.
// master drives the ID side and EX backpressure; slave is the stage.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              id_valid;
  logic              id_ready;
  logic [31:0]       id_instr;
  logic [DATA_W-1:0] id_pc;
  logic [DATA_W-1:0] id_rd1;
  logic [DATA_W-1:0] id_rd2;
  logic [DATA_W-1:0] id_imm;
  logic              id_alusrc;
  logic              id_memtoreg;
  logic              id_regwrite;
  logic              id_memread;
  logic              id_memwrite;
  logic              id_branch;
  logic [1:0]        id_aluop;
  logic              flush;
  logic              ex_ready;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc;
  logic [DATA_W-1:0] ex_rd1;
  logic [DATA_W-1:0] ex_rd2;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_W-1:0]  ex_rs1;
  logic [REG_W-1:0]  ex_rs2;
  logic [REG_W-1:0]  ex_rd;
  logic [2:0]        ex_funct3;
  logic [6:0]        ex_funct7;
  logic              ex_alusrc;
  logic              ex_memtoreg;
  logic              ex_regwrite;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_branch;
  logic [1:0]        ex_aluop;

  modport master (
    output id_valid, id_instr, id_pc, id_rd1, id_rd2, id_imm,
    output id_alusrc, id_memtoreg, id_regwrite, id_memread,
    output id_memwrite, id_branch, id_aluop, flush, ex_ready,
    input  id_ready, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm,
    input  ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7,
    input  ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
    input  ex_memwrite, ex_branch, ex_aluop
  );

  modport slave (
    input  id_valid, id_instr, id_pc, id_rd1, id_rd2, id_imm,
    input  id_alusrc, id_memtoreg, id_regwrite, id_memread,
    input  id_memwrite, id_branch, id_aluop, flush, ex_ready,
    output id_ready, ex_valid, ex_pc, ex_rd1, ex_rd2, ex_imm,
    output ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7,
    output ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
    output ex_memwrite, ex_branch, ex_aluop
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush and EX backpressure.
// Optional ID_EX_STATS_EN adds saturating bubble/flush counters.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic        clk,
  input  logic        reset,
  id_ex_stage_if.slave bus
`ifdef ID_EX_STATS_EN
  ,
  output logic [31:0] bubble_count,
  output logic [31:0] flush_count
`endif
);

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic [1:0] aluop;
  } ctrl_t;

  typedef struct packed {
    logic              valid;
    ctrl_t             ctrl;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
  } id_ex_t;

  id_ex_t ex_q;
  id_ex_t cap;
  id_ex_t kill;

  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic [6:0]       opcode;
  logic             uses_rs2;
  logic             hazard;
  logic             do_flush;
  logic             do_bubble;
  logic             do_load;

  assign rs1    = REG_W'(bus.id_instr[19:15]);
  assign rs2    = REG_W'(bus.id_instr[24:20]);
  assign opcode = bus.id_instr[6:0];

  assign uses_rs2 = (opcode == 7'b0110011) |
                    (opcode == 7'b0100011) |
                    (opcode == 7'b1100011);

  assign hazard = bus.id_valid & ex_q.valid &
                  ex_q.ctrl.memread & (ex_q.rd != '0) &
                  ((ex_q.rd == rs1) |
                   (uses_rs2 & (ex_q.rd == rs2)));

  assign bus.id_ready = bus.ex_ready & ~hazard & ~bus.flush;

  // mutually exclusive selects; none set means hold
  assign do_flush  = bus.flush;
  assign do_load   = ~bus.flush & bus.ex_ready &
                     ~hazard & bus.id_valid;
  assign do_bubble = ~bus.flush & bus.ex_ready &
                     (hazard | ~bus.id_valid);

  always_comb begin
    cap               = '0;
    cap.valid         = 1'b1;
    cap.ctrl.alusrc   = bus.id_alusrc;
    cap.ctrl.memtoreg = bus.id_memtoreg;
    cap.ctrl.regwrite = bus.id_regwrite;
    cap.ctrl.memread  = bus.id_memread;
    cap.ctrl.memwrite = bus.id_memwrite;
    cap.ctrl.branch   = bus.id_branch;
    cap.ctrl.aluop    = bus.id_aluop;
    cap.pc            = bus.id_pc;
    cap.rd1           = bus.id_rd1;
    cap.rd2           = bus.id_rd2;
    cap.imm           = bus.id_imm;
    cap.rs1           = rs1;
    cap.rs2           = rs2;
    cap.rd            = REG_W'(bus.id_instr[11:7]);
    cap.funct3        = bus.id_instr[14:12];
    cap.funct7        = bus.id_instr[31:25];
    kill              = cap;
    kill.valid        = 1'b0;
    kill.ctrl         = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      unique case (1'b1)
        do_flush:  ex_q <= kill;
        do_bubble: ex_q <= kill;
        do_load:   ex_q <= cap;
        default:   ex_q <= ex_q;
      endcase
    end
  end

  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_pc       = ex_q.pc;
  assign bus.ex_rd1      = ex_q.rd1;
  assign bus.ex_rd2      = ex_q.rd2;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_rs1      = ex_q.rs1;
  assign bus.ex_rs2      = ex_q.rs2;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_funct3   = ex_q.funct3;
  assign bus.ex_funct7   = ex_q.funct7;
  assign bus.ex_alusrc   = ex_q.ctrl.alusrc;
  assign bus.ex_memtoreg = ex_q.ctrl.memtoreg;
  assign bus.ex_regwrite = ex_q.ctrl.regwrite;
  assign bus.ex_memread  = ex_q.ctrl.memread;
  assign bus.ex_memwrite = ex_q.ctrl.memwrite;
  assign bus.ex_branch   = ex_q.ctrl.branch;
  assign bus.ex_aluop    = ex_q.ctrl.aluop;

`ifdef ID_EX_STATS_EN
  logic bubble_inc;

  // only load-use bubbles count, not idle bubbles
  assign bubble_inc = ~bus.flush & bus.ex_ready & hazard;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      if (bubble_inc && bubble_count != '1)
        bubble_count <= bubble_count + 32'd1;
      if (bus.flush && flush_count != '1)
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule
